pll_config_sequencer: RTL and testbench

//  Sequences PLL programming: on start, streams the NWORDS 32-bit register words of a selected

---
 rtl/pll_pkg.sv | 25 ++
 rtl/pll_lock_qualifier.sv | 57 +++++
 rtl/pll_config_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pll_config_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL configuration sequencer.
// Holds the sequencer state encoding and the reference register profile.
package pll_pkg;

    localparam int PLL_WORD_W     = 32;
    localparam int PLL_DEF_NWORDS = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT_DONE,
        S_SETTLE,
        S_WAIT_LOCK,
        S_DONE,
        S_FAIL
    } pll_state_e;

    // Index 0 is the last word written; index NWORDS-1 goes out first.
    localparam logic [PLL_WORD_W-1:0] PLL_DEF_PROFILE [PLL_DEF_NWORDS] = '{
        32'h0000_0000, 32'h0800_8011, 32'h1900_8E42,
        32'h0000_04B3, 32'h009C_803C, 32'h0058_0005
    };

endpackage

// File: rtl/pll_lock_qualifier.sv
// Synchronizes the asynchronous lock detect and qualifies it: lock_ok after
// LOCK_STABLE consecutive high cycles, timeout after LOCK_TO enabled cycles.
module pll_lock_qualifier #(
    parameter int LOCK_TO     = 65535,
    parameter int LOCK_STABLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic lock_det,
    output logic lock_ok,
    output logic timeout
);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TO + 1);

    logic [1:0]    sync_q;
    logic          lock_s;
    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] to_q, to_d;

    assign lock_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= '0;
            to_q     <= '0;
        end else begin
            sync_q   <= {sync_q[0], lock_det};
            stable_q <= stable_d;
            to_q     <= to_d;
        end
    end

    // Both counters saturate so they never wrap while the FSM is deciding.
    always_comb begin
        stable_d = stable_q;
        to_d     = to_q;
        if (clr) begin
            stable_d = '0;
            to_d     = '0;
        end else if (en) begin
            if (!lock_s)
                stable_d = '0;
            else if (stable_q != SW'(LOCK_STABLE))
                stable_d = stable_q + 1'b1;
            if (to_q != TW'(LOCK_TO - 1))
                to_d = to_q + 1'b1;
        end
    end

    assign lock_ok = en && lock_s && (stable_q == SW'(LOCK_STABLE - 1));
    assign timeout = en && (to_q == TW'(LOCK_TO - 1));

endmodule

// File: rtl/pll_config_sequencer.sv
// Streams a stored register profile to the serial PLL writer, waits for the
// PLL to settle and lock, and retries the whole profile on lock timeout.
module pll_config_sequencer
    import pll_pkg::*;
#(
    parameter int NPROF       = 4,
    parameter int NWORDS      = 6,
    parameter int SETTLE_CYC  = 1000,
    parameter int LOCK_TO     = 65535,
    parameter int LOCK_STABLE = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [$clog2(NPROF)-1:0]            profile_sel,
    input  logic                                cfg_we,
    input  logic [$clog2(NPROF*NWORDS)-1:0]     cfg_addr,
    input  logic [PLL_WORD_W-1:0]               cfg_wdata,
    output logic                                wr_valid,
    output logic [PLL_WORD_W-1:0]               wr_data,
    input  logic                                wr_ready,
    input  logic                                wr_done,
    input  logic                                lock_det,
    output logic                                busy,
    output logic                                done,
    output logic                                locked,
    output logic                                error,
    output logic [$clog2(MAX_RETRY+1)-1:0]      retry_cnt
);
    localparam int DEPTH = NPROF * NWORDS;
    localparam int PW    = $clog2(NPROF);
    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = $clog2(NWORDS);
    localparam int RW    = $clog2(MAX_RETRY + 1);
    localparam int CW    = $clog2(SETTLE_CYC + 1);

    pll_state_e      state_q, state_d;
    logic [PW-1:0]   prof_q, prof_d;
    logic [WW-1:0]   word_q, word_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic            locked_q, locked_d;
    logic            error_q, error_d;
    logic            done_q, done_d;
    logic            busy_w;
    logic            lock_ok, timeout;

    logic [PLL_WORD_W-1:0] mem [DEPTH];
    logic [PLL_WORD_W-1:0] rdata_q;
    logic [AW-1:0]         rd_addr;

    assign busy_w  = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
    assign rd_addr = AW'(int'(prof_q) * NWORDS + int'(word_q));

    // Table writes are locked out while a sequence runs so the active profile stays stable.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_w)
            mem[cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata_q <= '0;
        else if (state_q == S_READ)
            rdata_q <= mem[rd_addr];
    end

    pll_lock_qualifier #(
        .LOCK_TO    (LOCK_TO),
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lockq (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == S_SETTLE),
        .en      (state_q == S_WAIT_LOCK),
        .lock_det(lock_det),
        .lock_ok (lock_ok),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prof_q   <= '0;
            word_q   <= '0;
            retry_q  <= '0;
            settle_q <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prof_q   <= prof_d;
            word_q   <= word_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
            locked_q <= locked_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prof_d   = prof_q;
        word_d   = word_q;
        retry_d  = retry_q;
        settle_d = settle_q;
        locked_d = locked_q;
        error_d  = error_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d  = S_READ;
                    prof_d   = profile_sel;
                    word_d   = WW'(NWORDS - 1);
                    retry_d  = '0;
                    locked_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            S_READ: state_d = S_ISSUE;
            S_ISSUE: begin
                if (wr_ready)
                    state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (wr_done) begin
                    if (word_q == '0) begin
                        state_d  = S_SETTLE;
                        settle_d = CW'(SETTLE_CYC - 1);
                    end else begin
                        word_d  = word_q - 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == '0)
                    state_d = S_WAIT_LOCK;
                else
                    settle_d = settle_q - 1'b1;
            end
            S_WAIT_LOCK: begin
                // Qualification takes priority over a coincident timeout.
                if (lock_ok) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    locked_d = 1'b1;
                end else if (timeout) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        word_d  = WW'(NWORDS - 1);
                        state_d = S_READ;
                    end else begin
                        state_d = S_FAIL;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_valid  = (state_q == S_ISSUE);
    assign wr_data   = rdata_q;
    assign busy      = busy_w;
    assign done      = done_q;
    assign locked    = locked_q;
    assign error     = error_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_config_sequencer.sv
// Directed + randomized bench: writer model with 40-cycle done latency and a
// profile/attempt-level reference model of the expected word stream and outcome.
module tb_pll_config_sequencer;
    import pll_pkg::*;

    localparam int NP = 4;
    localparam int NW = 6;
    localparam int MR = 3;

    logic        clk, rst, start, cfg_we, wr_valid, wr_ready, wr_done, lock_det;
    logic        busy, done, locked, error;
    logic [1:0]  profile_sel, retry_cnt;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata, wr_data;

    pll_config_sequencer #(
        .NPROF(NP), .NWORDS(NW), .SETTLE_CYC(20), .LOCK_TO(100),
        .LOCK_STABLE(16), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .profile_sel(profile_sel),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
        .lock_det(lock_det), .busy(busy), .done(done), .locked(locked),
        .error(error), .retry_cnt(retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          sbase = 0;
    logic [31:0] seen [$];
    logic [31:0] tbl [NP][NW];

    // Writer model: ready while idle, done pulse 40 cycles after an accept.
    int wcnt = 0;
    bit acc  = 1'b0;
    initial begin
        wr_ready = 1'b1;
        wr_done  = 1'b0;
    end
    always @(negedge clk) begin
        wr_done = 1'b0;
        if (acc) begin
            acc      = 1'b0;
            wr_ready = 1'b0;
            wcnt     = 39;
        end else if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) begin
                wr_done  = 1'b1;
                wr_ready = 1'b1;
            end
        end
        if (wr_valid && wr_ready) begin
            seen.push_back(wr_data);
            acc = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int p, input int w, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = 5'(p * NW + w);
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
        tbl[p][w] = d;
    endtask

    // mode 0: lock_det high once k bursts have been accepted (k > MR+1 never locks)
    // mode 1: lock_det toggles 8/8 after the first burst, then held high
    task automatic run_seq(input int prof, input int k, input int mode, input bit noise);
        int cyc, nw, dcnt, dcyc, tstart, rise, att, succ;
        sbase  = seen.size();
        dcnt   = 0;
        dcyc   = -1;
        tstart = -1;
        rise   = -1000;
        profile_sel = 2'(prof);
        lock_det    = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc < 6000; cyc++) begin
            nw = seen.size() - sbase;
            if (mode == 0) begin
                lock_det = (nw >= k * NW);
            end else if (nw < NW) begin
                lock_det = 1'b0;
            end else begin
                if (tstart < 0) tstart = cyc;
                if (cyc - tstart == 96) rise = cyc;
                lock_det = (cyc - tstart >= 96) || (((cyc - tstart) % 16) < 8);
            end
            if (noise) begin
                start       = busy && (cyc % 7 == 3);
                profile_sel = 2'($urandom_range(0, NP - 1));
                cfg_we      = busy && (cyc % 5 == 2);
                cfg_addr    = 5'(prof * NW + cyc % NW);
                cfg_wdata   = $urandom;
            end
            @(negedge clk);
            if (done) begin
                dcnt++;
                dcyc = cyc;
            end
            if (!busy) break;
        end
        start  = 1'b0;
        cfg_we = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("seq_finished", 32'(cyc < 6000), 32'd1);
        succ = (mode == 1 || k <= MR + 1) ? 1 : 0;
        att  = (mode == 1 || k < 1) ? 1 : ((k > MR + 1) ? MR + 1 : k);
        chk("word_count", 32'(seen.size() - sbase), 32'(att * NW));
        for (int i = 0; i < att * NW; i++)
            if (sbase + i < seen.size())
                chk($sformatf("word[%0d]", i), seen[sbase + i], tbl[prof][NW - 1 - (i % NW)]);
        chk("done_pulses", 32'(dcnt), 32'(succ));
        chk("locked", 32'(locked), 32'(succ));
        chk("error", 32'(error), 32'(1 - succ));
        chk("retry_cnt", 32'(retry_cnt), 32'(att - 1));
        chk("busy_end", 32'(busy), 32'd0);
        if (mode == 1)
            chk("qualify_latency", 32'((dcyc - rise) >= 16 && (dcyc - rise) <= 20), 32'd1);
    endtask

    initial begin
        int b;
        rst = 1'b1; start = 1'b0; lock_det = 1'b0; cfg_we = 1'b0;
        profile_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(wr_valid), 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_flags", {28'd0, done, locked, error, 1'b0}, 32'd0);
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int p = 0; p < NP; p++)
            for (int w = 0; w < NW; w++)
                cfg_write(p, w, (p == 1) ? PLL_DEF_PROFILE[w] : $urandom);

        // Basic lock on first attempt with the reference profile
        run_seq(1, 1, 0, 1'b0);
        chk("t1_first_word", seen[sbase], 32'h0058_0005);
        chk("t1_last_word", seen[sbase + NW - 1], 32'h0000_0000);

        // Never locks: all retries used
        run_seq(1, 5, 0, 1'b0);
        // Locks after the second burst
        run_seq(1, 2, 0, 1'b0);
        // Toggling lock, then steady
        run_seq(0, 0, 1, 1'b0);
        // Start and table writes while busy are ignored; table unchanged afterwards
        run_seq(3, 1, 0, 1'b1);
        run_seq(3, 1, 0, 1'b0);

        // Reset during the third word's writer wait
        b = seen.size();
        profile_sel = 2'd2;
        lock_det    = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && seen.size() - b < 3; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(wr_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("no_words_after_rst", 32'(seen.size() - b), 32'd3);
        run_seq(2, 1, 0, 1'b0);

        // Randomized rounds: idle table rewrite, random profile and lock point
        for (int r = 0; r < 4; r++) begin
            cfg_write($urandom_range(0, NP - 1), $urandom_range(0, NW - 1), $urandom);
            run_seq($urandom_range(0, NP - 1), $urandom_range(1, 5), 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
